// File: rtl/key_tone_scheduler.sv
// Shares one square-wave tone generator among debounced keys; the highest eligible key wins.
// Pitch changes and stop are applied only on generator toggle edges so the output never glitches.
module key_tone_scheduler #(
    parameter int unsigned C_CLK_FRQ    = 100_000_000,
    parameter int unsigned C_KEYS       = 8,
    parameter int unsigned C_DIV_W      = 24,
    parameter int unsigned C_HOLD_MS    = 5,
    parameter int unsigned C_RELEASE_MS = 50
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic [C_KEYS-1:0]           key,
    input  logic [C_KEYS*C_DIV_W-1:0]   div_tbl,
    input  logic                        tone_edge,
    output logic                        gen_en,
    output logic [C_DIV_W-1:0]          gen_div,
    output logic                        gen_load,
    output logic [$clog2(C_KEYS)-1:0]   active_key
);

    localparam int unsigned KEY_W    = $clog2(C_KEYS);
    localparam int unsigned MS_CYC   = C_CLK_FRQ / 1000;
    localparam int unsigned HOLD_CYC = MS_CYC * C_HOLD_MS;
    localparam int unsigned REL_CYC  = MS_CYC * C_RELEASE_MS;
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYC + 1);
    localparam int unsigned REL_W    = $clog2(REL_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_SWITCH,
        S_RELEASE,
        S_STOP
    } state_t;

    state_t              state;
    logic [C_KEYS-1:0]   sync1;
    logic [C_KEYS-1:0]   sync2;
    logic [C_KEYS-1:0]   deb;
    logic [HOLD_W-1:0]   hold_cnt [C_KEYS];
    logic [REL_W-1:0]    rel_cnt;

    logic                win_vld;
    logic [KEY_W-1:0]    win_key;
    logic [C_DIV_W-1:0]  win_div;
    logic                load_ok;

    // Synchronize each key, then accept a new level only after it has been stable for the hold time
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < C_KEYS; i++) hold_cnt[i] <= '0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            for (int i = 0; i < C_KEYS; i++) begin
                if (sync2[i] == deb[i]) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] == HOLD_W'(HOLD_CYC - 1)) begin
                    deb[i]      <= sync2[i];
                    hold_cnt[i] <= '0;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                end
            end
        end
    end

    // Highest debounced key with a non-zero half-period wins
    always_comb begin
        win_vld = 1'b0;
        win_key = '0;
        win_div = '0;
        for (int i = 0; i < C_KEYS; i++) begin
            if (deb[i] && (div_tbl[i*C_DIV_W +: C_DIV_W] != '0)) begin
                win_vld = 1'b1;
                win_key = KEY_W'(i);
                win_div = div_tbl[i*C_DIV_W +: C_DIV_W];
            end
        end
    end

    // A load directly after another load is deferred to the next toggle edge
    assign load_ok = tone_edge && !gen_load;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= S_IDLE;
            rel_cnt    <= '0;
            gen_en     <= 1'b0;
            gen_div    <= '0;
            gen_load   <= 1'b0;
            active_key <= '0;
        end else begin
            gen_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        gen_div    <= win_div;
                        gen_load   <= 1'b1;
                        gen_en     <= 1'b1;
                        active_key <= win_key;
                        state      <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (!win_vld) begin
                        rel_cnt <= '0;
                        state   <= S_RELEASE;
                    end else if (win_key != active_key) begin
                        if (load_ok) begin
                            gen_div    <= win_div;
                            gen_load   <= 1'b1;
                            active_key <= win_key;
                        end else begin
                            state <= S_SWITCH;
                        end
                    end
                end
                S_SWITCH: begin
                    if (!win_vld) begin
                        rel_cnt <= '0;
                        state   <= S_RELEASE;
                    end else if (win_key == active_key) begin
                        state <= S_PLAY;
                    end else if (load_ok) begin
                        gen_div    <= win_div;
                        gen_load   <= 1'b1;
                        active_key <= win_key;
                        state      <= S_PLAY;
                    end
                end
                S_RELEASE: begin
                    if (win_vld) begin
                        state <= (win_key == active_key) ? S_PLAY : S_SWITCH;
                    end else if (rel_cnt == REL_W'(REL_CYC - 1)) begin
                        state <= S_STOP;
                    end else begin
                        rel_cnt <= rel_cnt + REL_W'(1);
                    end
                end
                S_STOP: begin
                    if (win_vld) begin
                        state <= S_SWITCH;
                    end else if (tone_edge) begin
                        gen_en <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_tone_scheduler.sv
// Directed bench for key_tone_scheduler at 1 MHz / 4 keys; models the tone generator
// (one tone_edge every gen_div cycles) and checks load timing, switching and release tails.
module tb_key_tone_scheduler;

    localparam int unsigned KEYS  = 4;
    localparam int unsigned DIV_W = 24;

    logic                    clk = 1'b0;
    logic                    rstb;
    logic [KEYS-1:0]         key;
    logic [KEYS*DIV_W-1:0]   div_tbl;
    logic                    tone_edge;
    logic                    gen_en;
    logic [DIV_W-1:0]        gen_div;
    logic                    gen_load;
    logic [1:0]              active_key;

    int n_cmp   = 0;
    int n_err   = 0;
    int nload   = 0;
    int nen0    = 0;
    int bad_seq = 0;
    logic prev_te   = 1'b0;
    logic last_load = 1'b0;

    key_tone_scheduler #(
        .C_CLK_FRQ   (1_000_000),
        .C_KEYS      (KEYS),
        .C_DIV_W     (DIV_W),
        .C_HOLD_MS   (1),
        .C_RELEASE_MS(2)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .key       (key),
        .div_tbl   (div_tbl),
        .tone_edge (tone_edge),
        .gen_en    (gen_en),
        .gen_div   (gen_div),
        .gen_load  (gen_load),
        .active_key(active_key)
    );

    always #5 clk = ~clk;

    // Generator model: samples gen_div on gen_load, pulses tone_edge every period cycles
    logic [DIV_W-1:0] per;
    int               ph;
    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            per       <= '0;
            ph        <= 0;
            tone_edge <= 1'b0;
        end else begin
            tone_edge <= 1'b0;
            if (gen_load) begin
                per <= gen_div;
                ph  <= 0;
            end else if (gen_en && per != '0) begin
                if (ph >= int'(per) - 1) begin
                    ph        <= 0;
                    tone_edge <= 1'b1;
                end else begin
                    ph <= ph + 1;
                end
            end
        end
    end

    // Load strobe must never repeat back-to-back nor appear with the generator disabled
    always @(negedge clk) begin
        if (rstb) begin
            if (gen_load && last_load) bad_seq++;
            if (gen_load && !gen_en)   bad_seq++;
        end
        last_load = gen_load;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        prev_te = tone_edge;
        @(posedge clk);
        #1;
        if (gen_load) nload++;
        if (!gen_en)  nen0++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_load(input string tag, input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!gen_load && n < max);
        chk(tag, 32'(gen_load), 32'd1);
    endtask

    int n;

    initial begin
        rstb    = 1'b0;
        key     = '0;
        div_tbl = {24'd400, 24'd300, 24'd200, 24'd100};
        ticks(3);

        // Reset values
        chk("rst_gen_en", 32'(gen_en), 0);
        chk("rst_gen_div", 32'(gen_div), 0);
        chk("rst_gen_load", 32'(gen_load), 0);
        chk("rst_active_key", 32'(active_key), 0);
        rstb = 1'b1;
        ticks(2);

        // 1: single key start: 2 sync + 1000 hold + 1 register cycle
        key = 4'b0001;
        wait_load("t1_load_seen", 1200, n);
        chk("t1_latency", 32'(n), 32'd1003);
        chk("t1_gen_div", 32'(gen_div), 32'd100);
        chk("t1_gen_en", 32'(gen_en), 32'd1);
        chk("t1_active_key", 32'(active_key), 32'd0);

        // 2: higher key pressed -> load only right after a tone edge
        key = 4'b0101;
        wait_load("t2_load_seen", 1500, n);
        chk("t2_after_debounce", 32'(n > 1002), 32'd1);
        chk("t2_on_tone_edge", 32'(prev_te), 32'd1);
        chk("t2_gen_div", 32'(gen_div), 32'd300);
        chk("t2_active_key", 32'(active_key), 32'd2);

        // back to key 0
        key = 4'b0001;
        wait_load("t3_back_seen", 1600, n);
        chk("t3_back_on_edge", 32'(prev_te), 32'd1);
        chk("t3_back_gen_div", 32'(gen_div), 32'd100);
        chk("t3_back_active_key", 32'(active_key), 32'd0);

        // 3: key 2 chatters with 500-cycle pulses for 10 ms
        nload = 0;
        for (int i = 0; i < 20; i++) begin
            key[2] = ~key[2];
            ticks(500);
        end
        chk("t3_chatter_no_load", 32'(nload), 32'd0);
        chk("t3_chatter_gen_div", 32'(gen_div), 32'd100);
        chk("t3_chatter_active_key", 32'(active_key), 32'd0);

        // 4: release all: 1002 debounce + 1 + 2000 tail, then stop on the next tone edge
        key   = 4'b0000;
        nload = 0;
        n     = 0;
        do begin
            tick();
            n++;
        end while (gen_en && n < 4000);
        chk("t4_gen_en_off", 32'(gen_en), 32'd0);
        chk("t4_tail_min", 32'(n >= 3004), 32'd1);
        chk("t4_tail_max", 32'(n <= 3104), 32'd1);
        chk("t4_off_on_edge", 32'(prev_te), 32'd1);
        chk("t4_no_load", 32'(nload), 32'd0);

        // 5: restart, release, re-press so the debounced press lands ~1500 cycles into the tail
        key = 4'b0001;
        wait_load("t5_start_seen", 1200, n);
        chk("t5_start_gen_div", 32'(gen_div), 32'd100);
        key   = 4'b0000;
        nload = 0;
        nen0  = 0;
        ticks(1501);
        key = 4'b0001;
        ticks(1100);
        ticks(2500);
        chk("t5_repress_no_load", 32'(nload), 32'd0);
        chk("t5_tone_never_cut", 32'(nen0), 32'd0);
        chk("t5_gen_en", 32'(gen_en), 32'd1);
        chk("t5_active_key", 32'(active_key), 32'd0);

        // zero table entry makes key 1 ineligible
        div_tbl[1*DIV_W +: DIV_W] = '0;
        key   = 4'b0011;
        nload = 0;
        ticks(1500);
        chk("t5_zero_entry_no_load", 32'(nload), 32'd0);
        chk("t5_zero_entry_gen_div", 32'(gen_div), 32'd100);
        chk("t5_zero_entry_active", 32'(active_key), 32'd0);

        // 6: align to a tone edge so the switch to key 3 waits in SWITCH, then reset mid-wait
        n = 0;
        do begin
            tick();
            n++;
        end while (!tone_edge && n < 300);
        chk("t6_edge_found", 32'(tone_edge), 32'd1);
        key   = 4'b1001;
        nload = 0;
        ticks(1050);
        chk("t6_pending_no_load", 32'(nload), 32'd0);
        chk("t6_pending_gen_div", 32'(gen_div), 32'd100);
        rstb = 1'b0;
        #2;
        chk("t6_rst_gen_en", 32'(gen_en), 32'd0);
        chk("t6_rst_gen_div", 32'(gen_div), 32'd0);
        chk("t6_rst_gen_load", 32'(gen_load), 32'd0);
        chk("t6_rst_active_key", 32'(active_key), 32'd0);
        ticks(3);
        rstb = 1'b1;
        wait_load("t6_restart_seen", 1200, n);
        chk("t6_restart_latency", 32'(n), 32'd1003);
        chk("t6_restart_gen_div", 32'(gen_div), 32'd400);
        chk("t6_restart_active_key", 32'(active_key), 32'd3);
        chk("t6_restart_gen_en", 32'(gen_en), 32'd1);

        ticks(5);
        chk("load_sequence_rules", 32'(bad_seq), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
